// File: rtl/speed_pkg.sv
// Shared types and defaults for the speed_meter family.
// Holds the FSM state encoding and default sizing constants.
package speed_pkg;

    localparam int CNT_W_DEF          = 27;
    localparam int TIMEOUT_CYCLES_DEF = 100_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise is high for one cycle when the synchronized input goes 0 -> 1.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the input down the synchronizer/history chain
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Chain registers, cleared so a high input after reset looks like a rise
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/speed_meter.sv
// Measures the rising-edge-to-rising-edge period of a slow tick.
// Reports each period with a one-cycle strobe, flags a missing tick.
module speed_meter
    import speed_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             armed
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise;
    logic [CNT_W-1:0] count_inc;

    sync_edge u_sync_edge (
        .clk      (CLOCK_50),
        .reset    (reset),
        .async_in (tick_in),
        .rise     (rise)
    );

    // count stays below LIMIT while measuring, so this never wraps
    assign count_inc = count_q + ONE;

    // Next-state and output logic; an edge beats the limit
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    count_d = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = count_inc;
                    valid_d  = 1'b1;
                    count_d  = '0;
                end else if (count_inc == LIMIT) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                    count_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign armed        = (state_q == MEASURE);

endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter with a 1000-cycle limit.
// Expected values are hand-derived cycle counts.
module tb_speed_meter;

    localparam int TO = 1000;
    localparam int CW = 27;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick_in;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          timeout;
    logic          armed;

    int n_chk = 0;
    int n_err = 0;

    int n_strb = 0;
    int n_two  = 0;
    int n_b2b  = 0;
    int n_chg  = 0;
    logic [CW-1:0] last_p = '0;
    logic          pv_d   = 1'b0;
    logic [CW-1:0] po_d   = '0;

    int s;
    int s2;

    speed_meter #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .timeout      (timeout),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    // Strobe bookkeeping, sampled on the falling edge
    always @(negedge clk) begin
        if (period_valid) begin
            n_strb = n_strb + 1;
            last_p = period_out;
            if (period_out == CW'(2)) n_two = n_two + 1;
        end
        if (period_valid && pv_d) n_b2b = n_b2b + 1;
        if (!reset && !period_valid && period_out != po_d)
            n_chg = n_chg + 1;
        pv_d = period_valid;
        po_d = period_out;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        tick_in = 1'b0;
        cyc(3);
        chk("rst_period", 32'(period_out), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_armed", 32'(armed), 0);
        reset = 1'b0;
        cyc(5);

        // 50/50 square wave: first rise arms, later rises give 100
        tick_in = 1'b1;
        cyc(2);
        chk("arm_early", 32'(armed), 0);
        cyc(1);
        chk("arm_lat", 32'(armed), 1);
        chk("arm_nostrb", 32'(period_valid), 0);
        s = n_strb;
        cyc(47);
        tick_in = 1'b0;
        cyc(50);
        tick_in = 1'b1;
        cyc(2);
        chk("sq_early", 32'(period_valid), 0);
        cyc(1);
        chk("sq_valid", 32'(period_valid), 1);
        chk("sq_period", 32'(period_out), 100);
        cyc(1);
        chk("sq_pulse1", 32'(period_valid), 0);
        cyc(46);
        tick_in = 1'b0;
        cyc(50);
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1;
            cyc(50);
            tick_in = 1'b0;
            cyc(50);
        end
        chk("sq_strobes", 32'(n_strb - s), 4);
        chk("sq_last", 32'(last_p), 100);

        // Timeout: last edge processed at E, limit reached at E+1000
        tick_in = 1'b1;
        cyc(3);
        chk("to_pre_p", 32'(period_out), 100);
        s = n_strb;
        tick_in = 1'b0;
        cyc(999);
        chk("to_early", 32'(timeout), 0);
        cyc(1);
        chk("to_set", 32'(timeout), 1);
        chk("to_armed", 32'(armed), 0);
        chk("to_hold", 32'(period_out), 100);
        cyc(200);
        chk("to_nostrb", 32'(n_strb - s), 0);
        chk("to_level", 32'(timeout), 1);
        tick_in = 1'b1;
        cyc(3);
        chk("rearm_to", 32'(timeout), 0);
        chk("rearm_arm", 32'(armed), 1);
        chk("rearm_nostrb", 32'(n_strb - s), 0);

        // Edge on the limit cycle wins
        tick_in = 1'b0;
        cyc(997);
        tick_in = 1'b1;
        cyc(2);
        chk("lim_early", 32'(timeout), 0);
        cyc(1);
        chk("lim_valid", 32'(period_valid), 1);
        chk("lim_period", 32'(period_out), TO);
        chk("lim_to", 32'(timeout), 0);

        // Reset at count 40 discards the partial measurement
        tick_in = 1'b0;
        cyc(40);
        reset = 1'b1;
        cyc(1);
        chk("mr_period", 32'(period_out), 0);
        chk("mr_valid", 32'(period_valid), 0);
        chk("mr_timeout", 32'(timeout), 0);
        chk("mr_armed", 32'(armed), 0);
        reset = 1'b0;
        s = n_strb;
        cyc(5);
        tick_in = 1'b1;
        cyc(3);
        chk("mr_arm", 32'(armed), 1);
        chk("mr_nostrb", 32'(n_strb - s), 0);
        tick_in = 1'b0;
        cyc(57);
        tick_in = 1'b1;
        cyc(3);
        chk("mr_valid60", 32'(period_valid), 1);
        chk("mr_period60", 32'(period_out), 60);

        // Fastest tick: alternate every cycle
        tick_in = 1'b0;
        cyc(2);
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
        cyc(3);
        s  = n_strb;
        s2 = n_two;
        for (int i = 0; i < 21; i++) begin
            tick_in = 1'b1;
            cyc(1);
            tick_in = 1'b0;
            cyc(1);
        end
        cyc(4);
        chk("alt_strobes", 32'(n_strb - s), 21);
        chk("alt_two", 32'(n_two - s2), 20);
        chk("alt_last", 32'(last_p), 2);

        // Tick held high through reset release arms only
        tick_in = 1'b1;
        reset   = 1'b1;
        cyc(3);
        reset = 1'b0;
        s = n_strb;
        cyc(2);
        chk("hi_pre", 32'(armed), 0);
        cyc(1);
        chk("hi_arm", 32'(armed), 1);
        chk("hi_nostrb", 32'(period_valid), 0);
        tick_in = 1'b0;
        cyc(10);
        tick_in = 1'b1;
        cyc(3);
        chk("hi_valid", 32'(period_valid), 1);
        chk("hi_period", 32'(period_out), 13);
        chk("hi_strobes", 32'(n_strb - s), 1);

        cyc(2);
        chk("no_b2b", 32'(n_b2b), 0);
        chk("no_silent_chg", 32'(n_chg), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
